// File: rtl/nes_input_pkg.sv
// Shared types, key map and helpers for the NES joypad port block.
// Key map rows are players; columns follow btn_idx_e order.
package nes_input_pkg;

    localparam int NES_BTN_W   = 8;
    localparam int MAP_PLAYERS = 4;
    localparam int MAP_ENTRIES = 10;

    typedef enum logic [3:0] {
        BTN_A      = 4'd0,
        BTN_B      = 4'd1,
        BTN_SELECT = 4'd2,
        BTN_START  = 4'd3,
        BTN_UP     = 4'd4,
        BTN_DOWN   = 4'd5,
        BTN_LEFT   = 4'd6,
        BTN_RIGHT  = 4'd7,
        TURBO_A    = 4'd8,
        TURBO_B    = 4'd9
    } btn_idx_e;

    // A 0x00 entry is treated as unmapped and never matches an empty slot.
    localparam logic [0:MAP_PLAYERS-1][0:MAP_ENTRIES-1][7:0] KEYMAP = '{
        '{8'h0E, 8'h0D, 8'h2B, 8'h28, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h0C, 8'h18},
        '{8'h5A, 8'h59, 8'h5D, 8'h5E, 8'h52, 8'h51, 8'h50, 8'h4F, 8'h5B, 8'h5C},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
    };

    // Opposite directions held together cancel each other out.
    function automatic logic [NES_BTN_W-1:0] socd_mask(input logic [NES_BTN_W-1:0] b);
        logic [NES_BTN_W-1:0] r;
        r = b;
        if (b[BTN_UP] && b[BTN_DOWN]) begin
            r[BTN_UP]   = 1'b0;
            r[BTN_DOWN] = 1'b0;
        end else begin
            r = r;
        end
        if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
            r[BTN_LEFT]  = 1'b0;
            r[BTN_RIGHT] = 1'b0;
        end else begin
            r = r;
        end
        return r;
    endfunction

endpackage

// File: rtl/nes_joypad_ports_if.sv
// CPU-side $4016/$4017 access bus: strobe write, per-port read pulses, serial data.
interface nes_joypad_if #(
    parameter int NUM_PLAYERS = 2
);
    logic                   cpu_wr;
    logic                   cpu_wdata0;
    logic [NUM_PLAYERS-1:0] cpu_rd;
    logic [NUM_PLAYERS-1:0] rd_data;

    modport master (output cpu_wr, output cpu_wdata0, output cpu_rd, input rd_data);
    modport slave  (input cpu_wr, input cpu_wdata0, input cpu_rd, output rd_data);
endinterface

// File: rtl/nes_joypad_ports_shift.sv
// One controller port's 8-bit parallel-in/serial-out register.
// Write beats strobe beats read; reads shift in 1s like an official pad.
module nes_shift_port
    import nes_input_pkg::*;
(
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 cpu_wr,
    input  logic                 strobe,
    input  logic                 cpu_rd,
    input  logic [NES_BTN_W-1:0] buttons,
    output logic                 rd_data
);

    logic [NES_BTN_W-1:0] shift_d;
    logic [NES_BTN_W-1:0] shift_q;

    // Next shift-register value by load/reload/shift/hold priority.
    always_comb begin
        shift_d = shift_q;
        if (cpu_wr) begin
            shift_d = buttons;
        end else if (strobe) begin
            shift_d = buttons;
        end else if (cpu_rd) begin
            shift_d = {1'b1, shift_q[NES_BTN_W-1:1]};
        end else begin
            shift_d = shift_q;
        end
    end

    // Shift register state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign rd_data = shift_q[0];

endmodule

// File: rtl/nes_joypad_ports.sv
// USB keycode pool to NES controller ports: input register, key decode,
// SOCD masking, frame-based turbo, shared strobe and per-port shift registers.
module nes_joypad_ports
    import nes_input_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_KEYCODES = 6,
    parameter int TURBO_FRAMES = 2,
    parameter int SOCD_MASK    = 1
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic [NUM_KEYCODES*8-1:0]       keycodes,
    input  logic                            frame_sync,
    nes_joypad_if.slave                     bus,
    output logic [NUM_PLAYERS*NES_BTN_W-1:0] buttons
);

    localparam int CNT_W = $clog2(TURBO_FRAMES + 1);

    logic [NUM_KEYCODES*8-1:0]           keycodes_q;
    logic [NUM_PLAYERS-1:0][MAP_ENTRIES-1:0] hit_s;
    logic [NUM_PLAYERS*NES_BTN_W-1:0]    buttons_d;
    logic [NUM_PLAYERS*NES_BTN_W-1:0]    buttons_q;
    logic                                fs_q;
    logic                                frame_tick_s;
    logic [CNT_W-1:0]                    cnt_d;
    logic [CNT_W-1:0]                    cnt_q;
    logic                                phase_d;
    logic                                phase_q;
    logic                                strobe_d;
    logic                                strobe_q;
    logic [NUM_PLAYERS-1:0]              rd_data_s;

    // Match every mapped code against every non-empty slot.
    always_comb begin
        hit_s = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            for (int b = 0; b < MAP_ENTRIES; b++) begin
                for (int k = 0; k < NUM_KEYCODES; k++) begin
                    hit_s[p][b] = hit_s[p][b] |
                        ((KEYMAP[p][b] != 8'h00) && (keycodes_q[8*k +: 8] == KEYMAP[p][b]));
                end
            end
        end
    end

    // Per-player button byte: optional SOCD cancel, then turbo on A/B.
    always_comb begin
        buttons_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            buttons_d[NES_BTN_W*p +: NES_BTN_W] = (SOCD_MASK != 0) ?
                socd_mask(hit_s[p][NES_BTN_W-1:0]) : hit_s[p][NES_BTN_W-1:0];
            buttons_d[NES_BTN_W*p + 0] = buttons_d[NES_BTN_W*p + 0] | (hit_s[p][TURBO_A] & phase_q);
            buttons_d[NES_BTN_W*p + 1] = buttons_d[NES_BTN_W*p + 1] | (hit_s[p][TURBO_B] & phase_q);
        end
    end

    assign frame_tick_s = fs_q & ~frame_sync;

    // Shared turbo frame counter; phase flips each time it wraps.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (frame_tick_s) begin
            if (cnt_q == CNT_W'(TURBO_FRAMES - 1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                phase_d = phase_q;
            end
        end else begin
            cnt_d   = cnt_q;
            phase_d = phase_q;
        end
    end

    // Strobe follows D0 of the latest $4016 write.
    always_comb begin
        if (bus.cpu_wr) begin
            strobe_d = bus.cpu_wdata0;
        end else begin
            strobe_d = strobe_q;
        end
    end

    // Pipeline, turbo and strobe state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            keycodes_q <= '0;
            buttons_q  <= '0;
            fs_q       <= 1'b1;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            keycodes_q <= keycodes;
            buttons_q  <= buttons_d;
            fs_q       <= frame_sync;
            cnt_q      <= cnt_d;
            phase_q    <= phase_d;
            strobe_q   <= strobe_d;
        end
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_port
        nes_shift_port u_port (
            .Clk     (Clk),
            .Reset_n (Reset_n),
            .cpu_wr  (bus.cpu_wr),
            .strobe  (strobe_q),
            .cpu_rd  (bus.cpu_rd[p]),
            .buttons (buttons_q[NES_BTN_W*p +: NES_BTN_W]),
            .rd_data (rd_data_s[p])
        );
    end

    assign bus.rd_data = rd_data_s;
    assign buttons     = buttons_q;

endmodule
